// File: rtl/td4_pkg.sv
// Shared encodings and sizes for the TD4 program controller slice.
package td4_pkg;

  localparam int IMEM_DEPTH = 16;
  localparam int INSTR_W    = 8;
  localparam int IADDR_W    = 4;
  localparam int CMD_W      = 3;

  // Host command opcodes; any other value is a NOP.
  localparam logic [CMD_W-1:0] CMD_WRITE   = 3'b000;
  localparam logic [CMD_W-1:0] CMD_RUN     = 3'b001;
  localparam logic [CMD_W-1:0] CMD_HALT    = 3'b010;
  localparam logic [CMD_W-1:0] CMD_STEP    = 3'b011;
  localparam logic [CMD_W-1:0] CMD_RESTART = 3'b100;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10,
    ST_RESTART  = 2'b11
  } state_e;

endpackage

// File: rtl/td4_prog_mem.sv
// 16x8 instruction store: flop array, synchronous write, combinational fetch.
module td4_prog_mem
  import td4_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               we_i,
  input  logic [IADDR_W-1:0] waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [IADDR_W-1:0] raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [IMEM_DEPTH];

  // Array clears to zero on reset; host writes land at the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/td4_prog_ctrl.sv
// Run/halt/step controller for the TD4 core: owns the program store, gates
// core updates through cpu_en, and handles the divider and breakpoint.
module td4_prog_ctrl
  import td4_pkg::*;
#(
  parameter int DIV_W   = 24,
  parameter int DIV_MAX = 0
)
(
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [CMD_W-1:0]   cmd_op,
  input  logic [IADDR_W-1:0] cmd_addr,
  input  logic [INSTR_W-1:0] cmd_data,
  input  logic               bp_en,
  input  logic [IADDR_W-1:0] bp_addr,
  input  logic [IADDR_W-1:0] cpu_ip,
  output logic [INSTR_W-1:0] cpu_instr,
  output logic               cpu_en,
  output logic               cpu_rst_n,
  output logic [1:0]         state,
  output logic               bp_hit,
  output logic               err
);

  localparam logic [DIV_W-1:0] DIV_TERM = DIV_W'(DIV_MAX);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             rcnt_q, rcnt_d;
  logic             bp_hit_q, bp_hit_d;
  logic             bp_skip_q, bp_skip_d;

  logic acc, acc_write, acc_run, acc_halt, acc_step, acc_restart;
  logic idle_like, running, div_term, bp_stop, run_fire, mem_we;

  // Command acceptance and per-cycle event decode.
  always_comb begin
    acc         = cmd_valid && (state_q != ST_RESTART);
    acc_write   = acc && (cmd_op == CMD_WRITE);
    acc_run     = acc && (cmd_op == CMD_RUN);
    acc_halt    = acc && (cmd_op == CMD_HALT);
    acc_step    = acc && (cmd_op == CMD_STEP);
    acc_restart = acc && (cmd_op == CMD_RESTART);
    // STEPPING evaluates commands exactly as HALTED does.
    idle_like   = (state_q == ST_HALTED) || (state_q == ST_STEPPING);
    running     = (state_q == ST_RUNNING);
    div_term    = (div_q == DIV_TERM);
    // A breakpoint stop still records bp_hit when a HALT arrives together;
    // a RESTART in the same cycle takes over and records nothing.
    bp_stop     = running && div_term && bp_en && (cpu_ip == bp_addr)
                  && !bp_skip_q && !acc_restart;
    run_fire    = running && div_term && !bp_stop && !acc_halt && !acc_restart;
    mem_we      = acc_write && idle_like;
  end

  // State register plus divider, restart counter and breakpoint flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HALTED;
      div_q     <= '0;
      rcnt_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      bp_skip_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      rcnt_q    <= rcnt_d;
      bp_hit_q  <= bp_hit_d;
      bp_skip_q <= bp_skip_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALTED, ST_STEPPING: begin
        state_d = ST_HALTED;
        if (acc_run)          state_d = ST_RUNNING;
        else if (acc_step)    state_d = ST_STEPPING;
        else if (acc_restart) state_d = ST_RESTART;
      end
      ST_RUNNING: begin
        if (acc_restart)             state_d = ST_RESTART;
        else if (acc_halt || bp_stop) state_d = ST_HALTED;
      end
      ST_RESTART: begin
        if (rcnt_q) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // Divider, restart hold counter and sticky breakpoint bookkeeping.
  always_comb begin
    div_d     = div_q;
    rcnt_d    = 1'b0;
    bp_hit_d  = bp_hit_q;
    bp_skip_d = bp_skip_q;
    if (running) begin
      div_d = div_term ? '0 : div_q + DIV_W'(1);
    end else if (idle_like && acc_run) begin
      div_d = '0;
    end
    // Two-cycle hold: rcnt counts 0 then 1 while in RESTART.
    if (state_q == ST_RESTART) begin
      rcnt_d = ~rcnt_q;
    end
    // Skip lasts until the breakpoint instruction has actually executed.
    if (cpu_en) begin
      bp_skip_d = 1'b0;
    end
    if (bp_stop) begin
      bp_hit_d  = 1'b1;
      bp_skip_d = 1'b1;
    end
    if (acc_restart) begin
      bp_hit_d  = 1'b0;
      bp_skip_d = 1'b0;
    end
  end

  // Moore/Mealy outputs toward host and core.
  always_comb begin
    cmd_ready = (state_q != ST_RESTART);
    cpu_en    = (state_q == ST_STEPPING) || run_fire;
    cpu_rst_n = (state_q != ST_RESTART);
    err       = running && (acc_write || acc_step);
    state     = state_q;
    bp_hit    = bp_hit_q;
  end

  td4_prog_mem u_mem (
    .clock   (clock),
    .reset   (reset),
    .we_i    (mem_we),
    .waddr_i (cmd_addr),
    .wdata_i (cmd_data),
    .raddr_i (cpu_ip),
    .rdata_o (cpu_instr)
  );

endmodule

// File: tb/tb_td4_prog_ctrl.sv
// Bench for td4_prog_ctrl: directed scenarios plus randomized commands,
// all compared every cycle against a cycle-count based behavioural model.
module tb_td4_prog_ctrl;

  localparam int DIVM = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b111;
  logic [3:0] cmd_addr = 4'h0;
  logic [7:0] cmd_data = 8'h00;
  logic       bp_en = 1'b0;
  logic [3:0] bp_addr = 4'h0;
  logic [3:0] cpu_ip;
  logic [7:0] cpu_instr;
  logic       cpu_en, cpu_rst_n, bp_hit, err;
  logic [1:0] state;

  logic [3:0] core_ip;
  logic       ip_ovr_en = 1'b0;
  logic [3:0] ip_ovr = 4'h0;

  int n_total = 0;
  int n_pass  = 0;

  td4_prog_ctrl #(.DIV_W(24), .DIV_MAX(DIVM)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_ip(cpu_ip), .cpu_instr(cpu_instr), .cpu_en(cpu_en),
    .cpu_rst_n(cpu_rst_n), .state(state), .bp_hit(bp_hit), .err(err)
  );

  always #5 clock = ~clock;

  // Minimal core stand-in: ip advances on cpu_en, clears under cpu_rst_n.
  always @(posedge clock or negedge reset) begin
    if (!reset)          core_ip <= 4'h0;
    else if (!cpu_rst_n) core_ip <= 4'h0;
    else if (cpu_en)     core_ip <= core_ip + 4'h1;
  end
  assign cpu_ip = ip_ovr_en ? ip_ovr : core_ip;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model (absolute cycle bookkeeping) -------
  int          m_mode;        // 0 halted, 1 running, 2 stepping, 3 restart
  int          m_left;        // restart cycles remaining
  longint      m_cyc, m_next; // current cycle, cycle of next due run pulse
  logic [7:0]  m_mem [16];
  bit          m_hit, m_skip;

  always @(negedge clock) begin
    bit acc, due, bpz, halt_r, rst_r, e_en, e_err;
    if (!reset) begin
      chk("rst_state", 32'(state), 0);
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_en", 32'(cpu_en), 0);
      chk("rst_rstn", 32'(cpu_rst_n), 1);
      chk("rst_bphit", 32'(bp_hit), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_instr", 32'(cpu_instr), 0);
      m_mode = 0; m_left = 0; m_next = 0; m_hit = 0; m_skip = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    end else begin
      acc    = cmd_valid && (m_mode != 3);
      due    = (m_mode == 1) && (m_cyc == m_next);
      halt_r = acc && (cmd_op == 3'd2);
      rst_r  = acc && (cmd_op == 3'd4);
      bpz    = due && bp_en && (cpu_ip == bp_addr) && !m_skip && !rst_r;
      e_en   = (m_mode == 2) || (due && !bpz && !halt_r && !rst_r);
      e_err  = (m_mode == 1) && acc && (cmd_op == 3'd0 || cmd_op == 3'd3);
      chk("state", 32'(state), 32'(m_mode));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_mode != 3));
      chk("cpu_en", 32'(cpu_en), 32'(e_en));
      chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_mode != 3));
      chk("bp_hit", 32'(bp_hit), 32'(m_hit));
      chk("err", 32'(err), 32'(e_err));
      chk("cpu_instr", 32'(cpu_instr), 32'(m_mem[cpu_ip]));
      if (e_en) m_skip = 0;
      if (bpz) begin m_hit = 1; m_skip = 1; end
      case (m_mode)
        1: begin
          if (rst_r) begin m_mode = 3; m_left = 2; m_hit = 0; m_skip = 0; end
          else if (halt_r || bpz) m_mode = 0;
          else if (due) m_next = m_next + DIVM + 1;
        end
        3: begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
        default: begin
          m_mode = 0;
          if (acc) begin
            case (cmd_op)
              3'd0: m_mem[cmd_addr] = cmd_data;
              3'd1: begin m_mode = 1; m_next = m_cyc + 1 + DIVM; end
              3'd3: m_mode = 2;
              3'd4: begin m_mode = 3; m_left = 2; m_hit = 0; m_skip = 0; end
              default: ;
            endcase
          end
        end
      endcase
    end
    m_cyc++;
  end

  // ---------------- stimulus helpers (called at posedge+2) ---------------
  task automatic cyc_wait(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [7:0] d,
                      output logic s_err, output logic s_en);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    #1;
    s_err = err; s_en = cpu_en;
    @(posedge clock); #2;
    cmd_valid = 1'b0; cmd_op = 3'b111;
  endtask

  initial begin
    logic e, en;
    int k;
    int rst_hold;
    m_cyc = 0;
    cyc_wait(3);
    reset = 1'b1;
    chk("lit_reset_state", 32'(state), 0);
    chk("lit_reset_ready", 32'(cmd_ready), 1);
    chk("lit_reset_rstn", 32'(cpu_rst_n), 1);

    // Program writes with one-cycle visibility.
    send(3'd0, 4'h0, 8'h3C, e, en);
    chk("lit_write_visible", 32'(cpu_instr), 32'h3C);
    send(3'd0, 4'h1, 8'h36, e, en);
    chk("lit_instr_ip0", 32'(cpu_instr), 32'h3C);
    chk("lit_no_en_halted", 32'(cpu_en), 0);
    chk("lit_halted", 32'(state), 0);
    ip_ovr_en = 1'b1; ip_ovr = 4'h1; #1;
    chk("lit_instr_ip1", 32'(cpu_instr), 32'h36);
    ip_ovr_en = 1'b0;
    @(posedge clock); #2;

    // Run-rate divider and HALT in a terminal cycle.
    send(3'd1, 4'h0, 8'h00, e, en);
    k = 1;
    while (cpu_en !== 1'b1 && k < 20) begin cyc_wait(1); k++; end
    chk("lit_run_first_latency", 32'(k), 32'(1 + DIVM));
    cyc_wait(1);
    chk("lit_run_gap", 32'(cpu_en), 0);
    cyc_wait(3);
    chk("lit_run_second_pulse", 32'(cpu_en), 1);
    cyc_wait(4);
    send(3'd2, 4'h0, 8'h00, e, en);
    chk("lit_halt_terminal_no_pulse", 32'(en), 0);
    chk("lit_halt_state", 32'(state), 0);

    // RESTART: two low cycles, ready dropped, memory kept.
    send(3'd4, 4'h0, 8'h00, e, en);
    chk("lit_restart_rstn_c1", 32'(cpu_rst_n), 0);
    chk("lit_restart_ready_c1", 32'(cmd_ready), 0);
    cyc_wait(1);
    chk("lit_restart_rstn_c2", 32'(cpu_rst_n), 0);
    cyc_wait(1);
    chk("lit_restart_rstn_done", 32'(cpu_rst_n), 1);
    chk("lit_restart_halted", 32'(state), 0);
    chk("lit_restart_mem_kept", 32'(cpu_instr), 32'h3C);

    // Breakpoint at address 2, then resume through it.
    bp_en = 1'b1; bp_addr = 4'h2;
    send(3'd1, 4'h0, 8'h00, e, en);
    k = 0;
    while (state !== 2'b00 && k < 40) begin cyc_wait(1); k++; end
    chk("lit_bp_stop_in_time", 32'(k < 40), 1);
    chk("lit_bp_ip", 32'(cpu_ip), 2);
    chk("lit_bp_hit", 32'(bp_hit), 1);
    send(3'd1, 4'h0, 8'h00, e, en);
    k = 0;
    while (cpu_en !== 1'b1 && k < 20) begin cyc_wait(1); k++; end
    chk("lit_resume_pulse_at_bp", 32'(cpu_ip), 2);
    cyc_wait(1);
    chk("lit_resume_ip_adv", 32'(cpu_ip), 3);
    chk("lit_resume_running", 32'(state), 1);
    send(3'd2, 4'h0, 8'h00, e, en);
    bp_en = 1'b0;

    // Single steps.
    for (int i = 0; i < 3; i++) begin
      send(3'd3, 4'h0, 8'h00, e, en);
      chk("lit_step_pulse", 32'(cpu_en), 1);
      chk("lit_step_state", 32'(state), 2);
      cyc_wait(1);
      chk("lit_step_done", 32'(cpu_en), 0);
      chk("lit_step_halted", 32'(state), 0);
    end

    // Illegal commands while running.
    send(3'd1, 4'h0, 8'h00, e, en);
    cyc_wait(1);
    send(3'd0, 4'h0, 8'hFF, e, en);
    chk("lit_err_write_run", 32'(e), 1);
    send(3'd3, 4'h0, 8'h00, e, en);
    chk("lit_err_step_run", 32'(e), 1);
    send(3'd2, 4'h0, 8'h00, e, en);
    send(3'd4, 4'h0, 8'h00, e, en);
    cyc_wait(2);
    chk("lit_mem_after_illegal", 32'(cpu_instr), 32'h3C);
    chk("lit_bphit_cleared", 32'(bp_hit), 0);

    // Reset during RESTART clears memory.
    send(3'd4, 4'h0, 8'h00, e, en);
    reset = 1'b0;
    #1;
    chk("lit_midrst_state", 32'(state), 0);
    chk("lit_midrst_rstn", 32'(cpu_rst_n), 1);
    @(posedge clock); #2;
    reset = 1'b1;
    ip_ovr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      ip_ovr = 4'(i); #1;
      chk("lit_mem_cleared", 32'(cpu_instr), 0);
    end
    ip_ovr_en = 1'b0;
    @(posedge clock); #2;

    // Randomized command traffic.
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = int'($urandom_range(0, 15));
      cmd_valid = ($urandom_range(0, 2) == 0);
      if (r < 4)       cmd_op = 3'd0;
      else if (r < 7)  cmd_op = 3'd1;
      else if (r < 9)  cmd_op = 3'd2;
      else if (r < 11) cmd_op = 3'd3;
      else if (r < 12) cmd_op = 3'd4;
      else             cmd_op = 3'($urandom_range(0, 7));
      cmd_addr = 4'($urandom_range(0, 15));
      cmd_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 49) == 0) begin
        bp_en = ~bp_en;
        bp_addr = 4'($urandom_range(0, 15));
      end
      ip_ovr_en = ($urandom_range(0, 3) == 0);
      ip_ovr = 4'($urandom_range(0, 15));
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) reset = 1'b1;
      end else if ($urandom_range(0, 699) == 0) begin
        reset = 1'b0;
        rst_hold = 1;
      end
      @(posedge clock); #2;
    end
    reset = 1'b1;
    cmd_valid = 1'b0;
    ip_ovr_en = 1'b0;
    cyc_wait(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
